instr_fetch_buffer: RTL

Instruction fetch front end that drives the instruction memory through a request/response handshake and buffers fetched words in a small in-order queue. The queue feeds the IF/ID pipeline register. Control-transfer redirects from the execute/memory stage (PCSel with ALU target) flush the queue and discard in-flight responses. Decode stalls apply backpressure without losing or duplicating instructions.

---
 rtl/instr_fetch_buffer_if.sv | 49 ++++
 rtl/instr_fetch_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if
// Groups the handshake buses around the fetch buffer:
//   - instruction memory request  : imem_req_valid / imem_req_ready / imem_req_addr
//   - instruction memory response : imem_rsp_valid / imem_rsp_data
//   - control-transfer redirect   : redirect_valid / redirect_pc
//   - IF/ID output                : fetch_valid / fetch_ready / fetch_instr / fetch_pc
// Modport master is the fetch buffer; modport slave is its environment
// (instruction memory, execute-stage redirect and decode).
interface instr_fetch_buffer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_valid,
    input  fetch_ready,
    output fetch_instr,
    output fetch_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_instr,
    input  fetch_pc
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
// Instruction fetch front end. Issues word-aligned fetch requests to the
// instruction memory, buffers returned words with their PCs in a DEPTH-entry
// in-order queue and presents the queue head to the IF/ID register. A redirect
// flushes the queue, retargets fetching and discards responses still owed for
// the old path.
// Parameters:
//   DEPTH     : queue entries, also the cap on requests in flight + buffered words
//   RESET_PC  : first fetch address after reset
//   NOP_INSTR : fetch_instr value while the queue is empty
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset
//   bus   : instr_fetch_buffer_if.master (memory, redirect and IF/ID handshakes)
module instr_fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_buffer_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   req_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic [CW+1:0] credit_sum;
  logic          req_valid;
  logic          req_fire;
  logic          live_rsp;
  logic          dropped_rsp;
  logic          enq;
  logic          deq;
  logic          fetch_valid;

  // Every buffered word, outstanding request and response still to be
  // discarded holds one credit; a new request needs a free one, which
  // guarantees a live response always finds a free queue slot.
  assign credit_sum  = (CW+2)'(count) + (CW+2)'(inflight) + (CW+2)'(drop_cnt);
  assign req_valid   = !reset && !bus.redirect_valid && (credit_sum < (CW+2)'(DEPTH));
  assign req_fire    = req_valid && bus.imem_req_ready;

  // Responses owed to a flushed path arrive first (in-order memory), so they
  // are consumed while drop_cnt is nonzero. A response with nothing
  // outstanding is a protocol error and is ignored.
  assign dropped_rsp = bus.imem_rsp_valid && (drop_cnt != '0);
  assign live_rsp    = bus.imem_rsp_valid && (drop_cnt == '0) && (inflight != '0);

  assign fetch_valid = (count != '0) && !bus.redirect_valid;
  assign enq         = live_rsp && !bus.redirect_valid;
  assign deq         = fetch_valid && bus.fetch_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_pc;
  assign bus.fetch_valid    = fetch_valid;
  assign bus.fetch_instr    = (count != '0) ? q_instr[rd_ptr] : NOP_INSTR;
  assign bus.fetch_pc       = (count != '0) ? q_pc[rd_ptr]    : 32'h0000_0000;

  // Control state. A redirect takes priority: it empties the queue, restarts
  // both PCs at the target and converts everything still outstanding (minus a
  // response landing this very cycle, which is itself thrown away) into
  // responses to discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      req_pc   <= bus.redirect_pc;
      rsp_pc   <= bus.redirect_pc;
      inflight <= '0;
      drop_cnt <= drop_cnt - CW'(dropped_rsp) + inflight - CW'(live_rsp);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire) begin
        req_pc <= req_pc + 32'd4;
      end
      if (enq) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      inflight <= inflight + CW'(req_fire) - CW'(live_rsp);
      drop_cnt <= drop_cnt - CW'(dropped_rsp);
      count    <= count + CW'(enq) - CW'(deq);
    end
  end

  // Queue storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= bus.imem_rsp_data;
    end
  end

endmodule
